lcd_ctrl_gen2: RTL and testbench

LCD_CTRL_GEN2 -- requirements
Module: lcd_ctrl_gen2

---
 rtl/lcd_ctrl_pkg.sv | 17 +
 rtl/lcd_win_alu.sv | 37 +++
 rtl/lcd_ctrl_gen2.sv | 114 +++++++++++
 tb/tb_lcd_ctrl_gen2.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg: shared command codes, controller state encoding and default geometry.
package lcd_ctrl_pkg;
  localparam int DEF_DW = 8;
  localparam int DEF_IMG_W = 8;
  localparam int DEF_IMG_H = 8;
  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_EXEC, S_WRITE} state_t;
  localparam logic [3:0] CMD_WRITE = 4'd0;
  localparam logic [3:0] CMD_UP = 4'd1;
  localparam logic [3:0] CMD_DOWN = 4'd2;
  localparam logic [3:0] CMD_LEFT = 4'd3;
  localparam logic [3:0] CMD_RIGHT = 4'd4;
  localparam logic [3:0] CMD_AVG = 4'd5;
  localparam logic [3:0] CMD_MIRX = 4'd6;
  localparam logic [3:0] CMD_MIRY = 4'd7;
  localparam logic [3:0] CMD_MAX = 4'd8;
  localparam logic [3:0] CMD_MIN = 4'd9;
endpackage

// File: rtl/lcd_win_alu.sv
// lcd_win_alu: combinational 2x2 window transform; codes without a window effect pass pixels through.
module lcd_win_alu
  import lcd_ctrl_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic [3:0]    code,
  input  logic [DW-1:0] p0,
  input  logic [DW-1:0] p1,
  input  logic [DW-1:0] p2,
  input  logic [DW-1:0] p3,
  output logic [DW-1:0] q0,
  output logic [DW-1:0] q1,
  output logic [DW-1:0] q2,
  output logic [DW-1:0] q3
);
  logic [DW+1:0] sum;
  logic [DW-1:0] avg, mx01, mx23, mx, mn01, mn23, mn;
  always_comb begin
    sum = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
    avg = DW'(sum >> 2);
    mx01 = p0 > p1 ? p0 : p1;
    mx23 = p2 > p3 ? p2 : p3;
    mx = mx01 > mx23 ? mx01 : mx23;
    mn01 = p0 < p1 ? p0 : p1;
    mn23 = p2 < p3 ? p2 : p3;
    mn = mn01 < mn23 ? mn01 : mn23;
    q0 = code == CMD_AVG ? avg : code == CMD_MIRX ? p2 : code == CMD_MIRY ? p1 :
         code == CMD_MAX ? mx : code == CMD_MIN ? mn : p0;
    q1 = code == CMD_AVG ? avg : code == CMD_MIRX ? p3 : code == CMD_MIRY ? p0 :
         code == CMD_MAX ? mx : code == CMD_MIN ? mn : p1;
    q2 = code == CMD_AVG ? avg : code == CMD_MIRX ? p0 : code == CMD_MIRY ? p3 :
         code == CMD_MAX ? mx : code == CMD_MIN ? mn : p2;
    q3 = code == CMD_AVG ? avg : code == CMD_MIRX ? p1 : code == CMD_MIRY ? p2 :
         code == CMD_MAX ? mx : code == CMD_MIN ? mn : p3;
  end
endmodule

// File: rtl/lcd_ctrl_gen2.sv
// lcd_ctrl_gen2: loads an image from ROM, edits it through a movable 2x2 window, streams it to a result buffer.
module lcd_ctrl_gen2
  import lcd_ctrl_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  localparam int N = IMG_W * IMG_H,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  input  logic [DW-1:0] IROM_Q,
  output logic          IROM_EN,
  output logic [AW-1:0] IROM_A,
  output logic          IRB_RW,
  output logic [DW-1:0] IRB_D,
  output logic [AW-1:0] IRB_A,
  output logic          busy,
  output logic          done
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  state_t state, nxt;
  logic [3:0] cmd_r, cmd_n;
  logic [XW-1:0] x, x_n, xm;
  logic [YW-1:0] y, y_n, ym;
  logic [DW-1:0] mem [N];
  logic [AW-1:0] a0, a1, a2, a3, rom_a_n, irb_a_n;
  logic [DW-1:0] p0, p1, p2, p3, q0, q1, q2, q3, irb_d_n;
  logic rom_en_n, irb_rw_n, busy_n, done_n;
  // Power-of-two geometry makes y*IMG_W+x a plain concatenation.
  always_comb begin
    xm = x - XW'(1);
    ym = y - YW'(1);
    a0 = {ym, xm};
    a1 = {ym, x};
    a2 = {y, xm};
    a3 = {y, x};
    p0 = mem[a0];
    p1 = mem[a1];
    p2 = mem[a2];
    p3 = mem[a3];
  end
  lcd_win_alu #(.DW(DW)) u_alu (
    .code(cmd_r), .p0(p0), .p1(p1), .p2(p2), .p3(p3),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_LOAD;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_LOAD:  nxt = (!IROM_EN && IROM_A == AW'(N - 1)) ? S_IDLE : S_LOAD;
      S_IDLE:  nxt = !cmd_valid ? S_IDLE : cmd == CMD_WRITE ? S_WRITE : S_EXEC;
      S_EXEC:  nxt = S_IDLE;
      S_WRITE: nxt = (!IRB_RW && IRB_A == AW'(N - 1)) ? S_IDLE : S_WRITE;
      default: nxt = S_LOAD;
    endcase
  end
  // Next values of the registered outputs and the operation point.
  always_comb begin
    busy_n = nxt != S_IDLE;
    done_n = state == S_WRITE && nxt == S_IDLE;
    rom_en_n = !(state == S_LOAD && nxt == S_LOAD);
    rom_a_n = (state == S_LOAD && !IROM_EN) ? IROM_A + AW'(1) : IROM_A;
    irb_rw_n = !(state == S_WRITE && nxt == S_WRITE);
    irb_a_n = (state == S_WRITE && !IRB_RW) ? IRB_A + AW'(1) : '0;
    irb_d_n = irb_rw_n ? IRB_D : mem[irb_a_n];
    cmd_n = (state == S_IDLE && cmd_valid) ? cmd : cmd_r;
    x_n = state != S_EXEC ? x :
          (cmd_r == CMD_LEFT && x != XW'(1)) ? x - XW'(1) :
          (cmd_r == CMD_RIGHT && x != XW'(IMG_W - 1)) ? x + XW'(1) : x;
    y_n = state != S_EXEC ? y :
          (cmd_r == CMD_UP && y != YW'(1)) ? y - YW'(1) :
          (cmd_r == CMD_DOWN && y != YW'(IMG_H - 1)) ? y + YW'(1) : y;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      IROM_EN <= 1'b1;
      IROM_A <= '0;
      IRB_RW <= 1'b1;
      IRB_D <= '0;
      IRB_A <= '0;
      busy <= 1'b1;
      done <= 1'b0;
      cmd_r <= '0;
      x <= XW'(IMG_W / 2);
      y <= YW'(IMG_H / 2);
    end else begin
      IROM_EN <= rom_en_n;
      IROM_A <= rom_a_n;
      IRB_RW <= irb_rw_n;
      IRB_D <= irb_d_n;
      IRB_A <= irb_a_n;
      busy <= busy_n;
      done <= done_n;
      cmd_r <= cmd_n;
      x <= x_n;
      y <= y_n;
    end
  // Pixel store is never reset; every reset is followed by a full reload.
  always_ff @(posedge clk)
    if (state == S_LOAD && !IROM_EN) mem[IROM_A] <= IROM_Q;
    else if (state == S_EXEC) begin
      mem[a0] <= q0;
      mem[a1] <= q1;
      mem[a2] <= q2;
      mem[a3] <= q3;
    end
endmodule

// File: tb/tb_lcd_ctrl_gen2.sv
// tb_lcd_ctrl_gen2: directed checks of load, window commands, write-out and reset abort with ROM pixel i = i.
module tb_lcd_ctrl_gen2;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] cmd;
  logic cmd_valid;
  logic [7:0] irom_q;
  logic irom_en, irb_rw, busy, done;
  logic [5:0] irom_a, irb_a;
  logic [7:0] irb_d;
  logic [7:0] res [64];
  logic [7:0] exp_img [64];
  int nchk = 0, nfail = 0, last_busy = 0;
  int rd_n = 0, rd_bad = 0, wr_n = 0, wbad = 0, wseq = 0, done_n = 0;
  always #5 clk = ~clk;
  assign irom_q = 8'(irom_a);
  lcd_ctrl_gen2 dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .IROM_Q(irom_q),
    .IROM_EN(irom_en), .IROM_A(irom_a), .IRB_RW(irb_rw), .IRB_D(irb_d), .IRB_A(irb_a),
    .busy(busy), .done(done)
  );
  always @(posedge clk) begin
    if (!reset) begin
      rd_n = 0;
      rd_bad = 0;
    end else if (!irom_en) begin
      if (int'(irom_a) != rd_n) rd_bad++;
      rd_n++;
    end
    if (!irb_rw) begin
      res[irb_a] = irb_d;
      if (int'(irb_a) != wseq) wbad++;
      wseq++;
      wr_n++;
    end else wseq = 0;
    if (done) done_n++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int img_bad();
    int b = 0;
    for (int i = 0; i < 64; i++) if (res[i] !== exp_img[i]) b++;
    return b;
  endfunction
  task automatic rom_img();
    for (int i = 0; i < 64; i++) exp_img[i] = 8'(i);
  endtask
  task automatic do_load();
    int cyc = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
    end while (busy && cyc < 200);
    chk("load_cycles", cyc, 65);
    chk("rom_reads", rd_n, 64);
    chk("rom_order", rd_bad, 0);
    rom_img();
  endtask
  task automatic send(input logic [3:0] c, input int hold);
    int n = 0;
    cmd = c;
    cmd_valid = 1'b1;
    repeat (hold) @(negedge clk);
    cmd_valid = 1'b0;
    cmd = 4'd0;
    last_busy = 0;
    while (busy && n < 200) begin
      last_busy++;
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("busy_timeout", 1, 0);
  endtask
  task automatic do_write(input string tag);
    int w0 = wr_n, d0 = done_n, o0 = wbad;
    send(4'd0, 1);
    @(negedge clk);
    chk({tag, "_busy"}, last_busy, 65);
    chk({tag, "_cnt"}, wr_n - w0, 64);
    chk({tag, "_done"}, done_n - d0, 1);
    chk({tag, "_order"}, wbad - o0, 0);
    chk({tag, "_img"}, img_bad(), 0);
  endtask
  initial begin
    int n, w0, d0;
    reset = 1'b1;
    cmd = 4'd0;
    cmd_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_irom_en", irom_en, 1);
    chk("rst_irom_a", irom_a, 0);
    chk("rst_irb_rw", irb_rw, 1);
    chk("rst_irb_d", irb_d, 0);
    chk("rst_irb_a", irb_a, 0);
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    do_load();
    do_write("w_rom");
    send(4'd5, 1);
    chk("avg_busy", last_busy, 1);
    exp_img[27] = 31; exp_img[28] = 31; exp_img[35] = 31; exp_img[36] = 31;
    do_write("w_avg");
    reset = 1'b0;
    do_load();
    repeat (5) send(4'd1, 1);
    repeat (5) send(4'd3, 1);
    send(4'd8, 1);
    exp_img[0] = 9; exp_img[1] = 9; exp_img[8] = 9; exp_img[9] = 9;
    do_write("w_max");
    repeat (10) send(4'd2, 1);
    repeat (10) send(4'd4, 1);
    send(4'd5, 1);
    exp_img[54] = 58; exp_img[55] = 58; exp_img[62] = 58; exp_img[63] = 58;
    do_write("w_corner_avg");
    reset = 1'b0;
    do_load();
    send(4'd6, 1);
    exp_img[27] = 35; exp_img[28] = 36; exp_img[35] = 27; exp_img[36] = 28;
    do_write("w_mirx");
    send(4'd9, 1);
    exp_img[27] = 27; exp_img[28] = 27; exp_img[35] = 27; exp_img[36] = 27;
    do_write("w_min");
    reset = 1'b0;
    do_load();
    send(4'd15, 1);
    chk("nop_busy", last_busy, 1);
    do_write("w_nop");
    send(4'd6, 2);
    exp_img[27] = 35; exp_img[28] = 36; exp_img[35] = 27; exp_img[36] = 28;
    do_write("w_hold");
    send(4'd7, 1);
    exp_img[27] = 36; exp_img[28] = 35; exp_img[35] = 28; exp_img[36] = 27;
    do_write("w_miry");
    send(4'd4, 1);
    cmd = 4'd0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!(irb_rw == 1'b0 && irb_a == 6'd20) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach", n < 100, 1);
    w0 = wr_n;
    d0 = done_n;
    reset = 1'b0;
    #1;
    chk("abort_rw", irb_rw, 1);
    chk("abort_busy", busy, 1);
    do_load();
    chk("abort_writes", wr_n - w0, 0);
    chk("abort_done", done_n - d0, 0);
    send(4'd5, 1);
    exp_img[27] = 31; exp_img[28] = 31; exp_img[35] = 31; exp_img[36] = 31;
    do_write("w_after_abort");
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
